// File: rtl/smem_pkg.sv
// Shared widths, issue FSM state encoding and response tag values for the
// memory request issue path.
package smem_pkg;

  localparam int ADDR_W = 42;
  localparam int LINE_W = 512;

  localparam logic TAG_K = 1'b0;
  localparam logic TAG_L = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_K = 2'd1,
    ISSUE_L = 2'd2
  } issue_state_t;

  // Two byte addresses fall in the same 64-byte occurrence line.
  function automatic logic same_line(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:6] == b[ADDR_W-1:6];
  endfunction

endpackage

// File: rtl/mem_req_issue_if.sv
// Memory read request/response channels; master is the issuing block,
// slave is the memory side.
interface mem_req_issue_if;
  import smem_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_tag;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [LINE_W-1:0] mem_rsp_data;
  logic              mem_rsp_tag;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_tag, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_tag, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );
endinterface

// File: rtl/ctx_fifo.sv
// Context FIFO for accepted-but-uncompleted requests; exposes the head entry
// and the one behind it so the collector can complete while the head drains.
module ctx_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head_data,
  output logic [WIDTH-1:0]       next_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] entries_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (push) entries_reg[wr_ptr_reg] <= wr_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = entries_reg[rd_ptr_reg];
  assign next_data = entries_reg[rd_ptr_reg + PTR_W'(1)];
endmodule

// File: rtl/mem_req_issue.sv
// Issues k/l occurrence-line reads per request and pairs the responses with
// the request context. Same-line merging is enabled by MEM_REQ_MERGE_EN.
module mem_req_issue
  import smem_pkg::*;
#(
  parameter int CTX_W = 128,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  addr_k,
  input  logic [ADDR_W-1:0]  addr_l,
  input  logic [CTX_W-1:0]   ctx_in,
  output logic               stall,
  mem_req_issue_if.master    mem,
  output logic               out_valid,
  input  logic               out_stall,
  output logic [LINE_W-1:0]  out_line_k,
  output logic [LINE_W-1:0]  out_line_l,
  output logic [CTX_W-1:0]   out_ctx,
  output logic               err
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = CTX_W + 1;

  issue_state_t      state_reg;
  logic              req_valid_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic [ADDR_W-1:0] addr_l_reg;
  logic              req_tag_reg;
  logic              merged_reg;
  logic              exp_tag_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  head_data;
  logic [ENT_W-1:0]  next_data;
  logic [ENT_W-1:0]  pend_data;

  logic merge_hit, accept, req_fire, rsp_ready, rsp_fire, pop, has_pend;

`ifdef MEM_REQ_MERGE_EN
  assign merge_hit = same_line(addr_k, addr_l);
`else
  assign merge_hit = 1'b0;
`endif

  assign stall     = (state_reg != IDLE) || fifo_full;
  assign accept    = req_valid && !stall;
  assign req_fire  = req_valid_reg && mem.mem_req_ready;
  assign rsp_ready = !rst && !(out_valid && out_stall);
  assign rsp_fire  = mem.mem_rsp_valid && rsp_ready;
  assign pop       = out_valid && !out_stall;

  assign mem.mem_req_valid = req_valid_reg;
  assign mem.mem_req_addr  = req_addr_reg;
  assign mem.mem_req_tag   = req_tag_reg;
  assign mem.mem_rsp_ready = rsp_ready;

  // While the output register is occupied the FIFO head belongs to it, so
  // incoming responses complete the entry behind the head.
  assign has_pend  = !fifo_empty && (!out_valid || (fifo_count > CNT_W'(1)));
  assign pend_data = out_valid ? next_data : head_data;

  ctx_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_ctx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pop       (pop),
    .wr_data   ({ctx_in, merge_hit}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (head_data),
    .next_data (next_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      req_valid_reg <= 1'b0;
      req_addr_reg  <= '0;
      req_tag_reg   <= TAG_K;
      addr_l_reg    <= '0;
      merged_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          state_reg     <= ISSUE_K;
          req_valid_reg <= 1'b1;
          req_addr_reg  <= addr_k;
          req_tag_reg   <= TAG_K;
          addr_l_reg    <= addr_l;
          merged_reg    <= merge_hit;
        end
        ISSUE_K: if (req_fire) begin
          if (merged_reg) begin
            state_reg     <= IDLE;
            req_valid_reg <= 1'b0;
          end else begin
            state_reg    <= ISSUE_L;
            req_addr_reg <= addr_l_reg;
            req_tag_reg  <= TAG_L;
          end
        end
        ISSUE_L: if (req_fire) begin
          state_reg     <= IDLE;
          req_valid_reg <= 1'b0;
        end
        default: begin
          state_reg     <= IDLE;
          req_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // A response can only be accepted while the output register is free or
  // draining, so overwriting out_line_k never disturbs a held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_line_k  <= '0;
      out_line_l  <= '0;
      out_ctx     <= '0;
      err         <= 1'b0;
      exp_tag_reg <= TAG_K;
    end else begin
      if (pop) out_valid <= 1'b0;
      if (rsp_fire) begin
        if (!has_pend) begin
          err <= 1'b1;
        end else begin
          if (mem.mem_rsp_tag != exp_tag_reg) err <= 1'b1;
          if (exp_tag_reg == TAG_K) begin
            out_line_k <= mem.mem_rsp_data;
            if (pend_data[0]) begin
              out_line_l <= mem.mem_rsp_data;
              out_ctx    <= pend_data[ENT_W-1:1];
              out_valid  <= 1'b1;
            end else begin
              exp_tag_reg <= TAG_L;
            end
          end else begin
            out_line_l  <= mem.mem_rsp_data;
            out_ctx     <= pend_data[ENT_W-1:1];
            out_valid   <= 1'b1;
            exp_tag_reg <= TAG_K;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_req_issue.sv
// Directed self-checking bench for mem_req_issue (default CTX_W/DEPTH);
// expectations for same-line requests follow MEM_REQ_MERGE_EN.
module tb_mem_req_issue;
  import smem_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] addr_k = '0;
  logic [ADDR_W-1:0] addr_l = '0;
  logic [127:0]      ctx_in = '0;
  logic              stall;
  logic              out_valid;
  logic              out_stall = 1'b0;
  logic [LINE_W-1:0] out_line_k;
  logic [LINE_W-1:0] out_line_l;
  logic [127:0]      out_ctx;
  logic              err;

  int total = 0;
  int bad   = 0;

  mem_req_issue_if mif ();

  mem_req_issue #(.CTX_W(128), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .addr_k     (addr_k),
    .addr_l     (addr_l),
    .ctx_in     (ctx_in),
    .stall      (stall),
    .mem        (mif),
    .out_valid  (out_valid),
    .out_stall  (out_stall),
    .out_line_k (out_line_k),
    .out_line_l (out_line_l),
    .out_ctx    (out_ctx),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Accept one request and let the issue sequence finish with ready held high.
  task automatic run_request(input logic [ADDR_W-1:0] k, input logic [ADDR_W-1:0] l,
                             input logic [127:0] c);
    req_valid = 1'b1; addr_k = k; addr_l = l; ctx_in = c;
    tick();
    req_valid = 1'b0;
    $display("accept k=%h l=%h ctx=%h", k, l, c);
    tick();
    tick();
  endtask

  task automatic send_rsp(input logic tag, input logic [LINE_W-1:0] data);
    mif.mem_rsp_valid = 1'b1; mif.mem_rsp_tag = tag; mif.mem_rsp_data = data;
    tick();
    mif.mem_rsp_valid = 1'b0;
    $display("response tag=%0d data=%h", tag, data[31:0]);
  endtask

  task automatic test_reset();
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (mif.mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", mif.mem_req_valid); end
    total++; if (mif.mem_rsp_ready !== 1'b0) begin bad++; $display("FAIL reset_rsp_ready got=%b exp=0", mif.mem_rsp_ready); end
    total++; if (out_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_out got=%b%b exp=00", out_valid, err); end
    total++; if (out_line_k !== '0 || out_ctx !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_ctx); end
    @(posedge clk); #3;
    rst = 1'b0;
    req_valid = 1'b1; addr_k = 42'h40; addr_l = 42'h80;
    tick();
    req_valid = 1'b0;
    total++; if (mif.mem_req_valid !== 1'b1) begin bad++; $display("FAIL first_accept got=%b exp=1", mif.mem_req_valid); end
    pulse_rst();
  endtask

  task automatic test_basic();
    logic [LINE_W-1:0] a = {16{32'hAAAA0001}};
    logic [LINE_W-1:0] b = {16{32'hBBBB0002}};
    req_valid = 1'b1; addr_k = 42'h100; addr_l = 42'h2C0; ctx_in = 128'h11;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL basic_idle_stall got=%b exp=0", stall); end
    tick();
    req_valid = 1'b0;
    total++; if (mif.mem_req_valid !== 1'b1 || mif.mem_req_addr !== 42'h100 || mif.mem_req_tag !== 1'b0)
      begin bad++; $display("FAIL basic_req_k got=%b %h %b exp=1 100 0", mif.mem_req_valid, mif.mem_req_addr, mif.mem_req_tag); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL basic_busy_stall got=%b exp=1", stall); end
    tick();
    total++; if (mif.mem_req_valid !== 1'b1 || mif.mem_req_addr !== 42'h2C0 || mif.mem_req_tag !== 1'b1)
      begin bad++; $display("FAIL basic_req_l got=%b %h %b exp=1 2c0 1", mif.mem_req_valid, mif.mem_req_addr, mif.mem_req_tag); end
    tick();
    total++; if (mif.mem_req_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL basic_issue_done got=%b%b exp=00", mif.mem_req_valid, stall); end
    send_rsp(1'b0, a);
    send_rsp(1'b1, b);
    total++; if (out_valid !== 1'b1 || out_line_k !== a || out_line_l !== b || out_ctx !== 128'h11)
      begin bad++; $display("FAIL basic_out got=%b %h %h %h exp=1 aaaa0001 bbbb0002 11", out_valid, out_line_k[31:0], out_line_l[31:0], out_ctx); end
    tick();
    total++; if (out_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL basic_pop got=%b%b exp=00", out_valid, err); end
  endtask

  task automatic test_full();
    logic [31:0] w;
    for (int i = 0; i < 8; i++) run_request(42'h1000 + 42'(i) * 42'h80, 42'h1040 + 42'(i) * 42'h80, 128'(i) + 128'hC000);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%b exp=1", stall); end
    req_valid = 1'b1; addr_k = 42'h9000; addr_l = 42'h9040;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (mif.mem_req_valid !== 1'b0) begin bad++; $display("FAIL full_ninth_ignored got=%b exp=0", mif.mem_req_valid); end
    end
    req_valid = 1'b0;
    send_rsp(1'b0, {16{32'hD0000000}});
    send_rsp(1'b1, {16{32'hE0000000}});
    total++; if (out_valid !== 1'b1 || out_ctx !== 128'hC000 || stall !== 1'b1)
      begin bad++; $display("FAIL full_first_out got=%b %h %b exp=1 c000 1", out_valid, out_ctx, stall); end
    // Back-to-back drain: each k response is accepted on the pop cycle.
    for (int i = 1; i < 8; i++) begin
      w = 32'hD0000000 + 32'(i);
      send_rsp(1'b0, {16{w}});
      if (i == 1) begin
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL full_stall_drop got=%b exp=0", stall); end
      end
      send_rsp(1'b1, {16{w + 32'h10000000}});
      total++; if (out_valid !== 1'b1 || out_ctx !== 128'(i) + 128'hC000 || out_line_k[31:0] !== w || out_line_l[31:0] !== w + 32'h10000000)
        begin bad++; $display("FAIL full_drain got=%b %h %h exp=1 %h %h", out_valid, out_ctx, out_line_k[31:0], 128'(i) + 128'hC000, w); end
    end
    tick();
    total++; if (out_valid !== 1'b0 || stall !== 1'b0 || err !== 1'b0)
      begin bad++; $display("FAIL full_empty got=%b%b%b exp=000", out_valid, stall, err); end
  endtask

  task automatic test_out_stall();
    logic [LINE_W-1:0] a = {16{32'h0A0A0A0A}};
    logic [LINE_W-1:0] b = {16{32'h0B0B0B0B}};
    logic [LINE_W-1:0] c = {16{32'h0C0C0C0C}};
    logic [LINE_W-1:0] d = {16{32'h0D0D0D0D}};
    run_request(42'h2000, 42'h2040, 128'h5151);
    out_stall = 1'b1;
    send_rsp(1'b0, a);
    send_rsp(1'b1, b);
    run_request(42'h3000, 42'h3040, 128'h5252);
    mif.mem_rsp_valid = 1'b1; mif.mem_rsp_tag = 1'b0; mif.mem_rsp_data = c;
    #1;
    total++; if (mif.mem_rsp_ready !== 1'b0) begin bad++; $display("FAIL ostall_rsp_ready got=%b exp=0", mif.mem_rsp_ready); end
    tick();
    tick();
    total++; if (out_valid !== 1'b1 || out_line_k !== a || out_line_l !== b || out_ctx !== 128'h5151)
      begin bad++; $display("FAIL ostall_hold got=%b %h %h %h exp=1 0a0a0a0a 0b0b0b0b 5151", out_valid, out_line_k[31:0], out_line_l[31:0], out_ctx); end
    out_stall = 1'b0;
    #1;
    total++; if (mif.mem_rsp_ready !== 1'b1) begin bad++; $display("FAIL ostall_release_ready got=%b exp=1", mif.mem_rsp_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || out_line_k !== c) begin bad++; $display("FAIL ostall_pop got=%b %h exp=0 0c0c0c0c", out_valid, out_line_k[31:0]); end
    mif.mem_rsp_tag = 1'b1; mif.mem_rsp_data = d;
    tick();
    mif.mem_rsp_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_line_k !== c || out_line_l !== d || out_ctx !== 128'h5252)
      begin bad++; $display("FAIL ostall_resume got=%b %h %h %h exp=1 0c0c0c0c 0d0d0d0d 5252", out_valid, out_line_k[31:0], out_line_l[31:0], out_ctx); end
    tick();
  endtask

  task automatic test_merge();
    int n = 0;
    int exp_n;
    logic [LINE_W-1:0] c = {16{32'hC0C0C0C0}};
    logic [LINE_W-1:0] d = {16{32'hD1D1D1D1}};
`ifdef MEM_REQ_MERGE_EN
    exp_n = 1;
`else
    exp_n = 2;
`endif
    req_valid = 1'b1; addr_k = 42'h400; addr_l = 42'h400; ctx_in = 128'h7777;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mif.mem_req_valid === 1'b1) n++;
      tick();
    end
    total++; if (n !== exp_n) begin bad++; $display("FAIL merge_req_count got=%0d exp=%0d", n, exp_n); end
    send_rsp(1'b0, c);
`ifndef MEM_REQ_MERGE_EN
    send_rsp(1'b1, d);
`endif
    total++;
    if (out_valid !== 1'b1 || out_line_k !== c || out_line_l !== ((exp_n == 1) ? c : d) || out_ctx !== 128'h7777)
      begin bad++; $display("FAIL merge_out got=%b %h %h %h exp_l=%h", out_valid, out_line_k[31:0], out_line_l[31:0], out_ctx, (exp_n == 1) ? c[31:0] : d[31:0]); end
    tick();
  endtask

  task automatic test_err_reset();
    logic [LINE_W-1:0] e1 = {16{32'hE1E1E1E1}};
    logic [LINE_W-1:0] e2 = {16{32'hE2E2E2E2}};
    run_request(42'h5000, 42'h5040, 128'h99);
    send_rsp(1'b1, e1);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_tag_set got=%b exp=1", err); end
    send_rsp(1'b1, e2);
    total++; if (out_valid !== 1'b1 || out_line_k !== e1 || out_line_l !== e2 || err !== 1'b1)
      begin bad++; $display("FAIL err_consume got=%b %h %h %b exp=1 e1e1e1e1 e2e2e2e2 1", out_valid, out_line_k[31:0], out_line_l[31:0], err); end
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    req_valid = 1'b1; addr_k = 42'h6000; addr_l = 42'h6040; ctx_in = 128'hAB;
    tick();
    req_valid = 1'b0;
    tick();
    mif.mem_req_ready = 1'b0;
    tick();
    total++; if (mif.mem_req_valid !== 1'b1 || mif.mem_req_addr !== 42'h6040 || mif.mem_req_tag !== 1'b1)
      begin bad++; $display("FAIL issue_l_hold got=%b %h %b exp=1 6040 1", mif.mem_req_valid, mif.mem_req_addr, mif.mem_req_tag); end
    rst = 1'b1;
    #1;
    total++; if (err !== 1'b0 || mif.mem_req_valid !== 1'b0 || out_valid !== 1'b0 || stall !== 1'b0 || mif.mem_rsp_ready !== 1'b0)
      begin bad++; $display("FAIL midreset_ctrl got=%b%b%b%b%b exp=00000", err, mif.mem_req_valid, out_valid, stall, mif.mem_rsp_ready); end
    total++; if (mif.mem_req_addr !== '0 || out_line_k !== '0 || out_line_l !== '0 || out_ctx !== '0)
      begin bad++; $display("FAIL midreset_data got=%h %h exp=0 0", mif.mem_req_addr, out_ctx); end
    #1;
    rst = 1'b0;
    mif.mem_req_ready = 1'b1;
    send_rsp(1'b0, e1);
    total++; if (err !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL empty_rsp got=%b%b exp=10", err, out_valid); end
    pulse_rst();
  endtask

  initial begin
    mif.mem_req_ready = 1'b1;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_tag   = 1'b0;
    mif.mem_rsp_data  = '0;
    test_reset();
    test_basic();
    test_full();
    test_out_stall();
    test_merge();
    test_err_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_req_issue.md
MEM_REQ_ISSUE -- requirements
Module: mem_req_issue

Interface
REQ-001 Parameter CTX_W, default 128, width of sideband context carried with each request (read_num, backward_i/j, status, primary, ...).
REQ-002 Parameter DEPTH, default 8, maximum accepted-but-uncompleted requests; power of two, minimum 2.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  request from CAL_KL stage (its request_valid).
REQ-006 addr_k, addr_l  in  42 each  occurrence-line byte addresses for k and l.
REQ-007 ctx_in  in  CTX_W  sideband captured with the request.
REQ-008 stall  out  1  back-pressure to CAL_KL; request accepted only when req_valid=1 and stall=0.
REQ-009 mem_req_valid / mem_req_ready  out / in  1 / 1  memory read request handshake.
REQ-010 mem_req_addr  out  42; mem_req_tag  out  1 (0=k, 1=l).
REQ-011 mem_rsp_valid / mem_rsp_ready  in / out  1 / 1; mem_rsp_data  in  512; mem_rsp_tag  in  1.
REQ-012 out_valid  out  1; out_stall  in  1; out_line_k, out_line_l  out  512 each; out_ctx  out  CTX_W.
REQ-013 err  out  1  sticky protocol-error flag.

Function
REQ-014 Issue FSM states IDLE, ISSUE_K, ISSUE_L; IDLE->ISSUE_K on accept; ISSUE_K->ISSUE_L on mem_req handshake; ISSUE_L->IDLE on mem_req handshake.
REQ-015 Accepted addresses and ctx_in registered at accept; mem_req_valid asserted the cycle after accept, addr_k with tag 0, then addr_l with tag 1.
REQ-016 mem_req_valid, mem_req_addr, mem_req_tag held stable while mem_req_ready=0.
REQ-017 stall = (FSM != IDLE) or (outstanding count == DEPTH); combinational from registered state only.
REQ-018 Context FIFO written at accept with {ctx_in, merged}; count +1 on accept, -1 on output handshake, unchanged on simultaneous both; pointers wrap modulo DEPTH.
REQ-019 Memory returns responses in issue order; collector expects tag 0 then tag 1 per request (tag 0 only when merged).
REQ-020 mem_rsp_ready = 1 unless output register holds valid data with out_stall=1.
REQ-021 k-response stored in out_line_k holding register; l-response completes the entry: out_valid asserted the cycle after the completing response handshake, out_ctx from FIFO head.
REQ-022 out_valid, out_line_k/l, out_ctx held until out_valid=1 and out_stall=0; FIFO popped on that cycle.
REQ-023 Response tag differing from expected sets err (sticky until reset); data still consumed as expected tag.
REQ-024 Response with empty FIFO sets err and is dropped.

Reset
REQ-025 rst asserted (any time, including mid-issue) forces FSM IDLE, count 0, pointers 0, err 0, stall 0, mem_req_valid 0, mem_rsp_ready 0, out_valid 0, all data outputs 0; in-flight requests discarded.
REQ-026 First accept possible in the first clk edge after rst deasserts.

Configuration
REQ-027 Macro MEM_REQ_MERGE_EN defined: addr_k[41:6]==addr_l[41:6] issues only the k request (ISSUE_K->IDLE), merged=1, response copied to both out_line_k and out_line_l.
REQ-028 MEM_REQ_MERGE_EN undefined: two requests always issued, merged always 0.

Structure
REQ-029 Shared package smem_pkg holds ADDR_W=42, LINE_W=512, issue FSM state enum, tag constants TAG_K/TAG_L.
REQ-030 Context FIFO is sub-module ctx_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, count).

Verification
REQ-031 Accept addr_k=0x100, addr_l=0x2C0, mem_req_ready=1 -> requests 0x100 tag 0 at t+1, 0x2C0 tag 1 at t+2; responses A,B -> out_valid with line_k=A, line_l=B.
REQ-032 8 accepts, no responses -> stall=1 after 8th accept; 9th req_valid ignored; one output handshake -> stall drops next cycle.
REQ-033 out_stall=1 with out_valid=1, mem_rsp_valid=1 -> mem_rsp_ready=0, outputs stable; release -> pop and resume.
REQ-034 MEM_REQ_MERGE_EN, addr_k=addr_l=0x400 -> one request; response C -> line_k=line_l=C; without macro -> two requests.
REQ-035 Response tag 1 when tag 0 expected -> err=1, stays 1; rst pulse mid-ISSUE_L -> all outputs 0, err 0, mem_req_valid 0.
